// File: rtl/alu_exec_unit.sv
// Single-issue ALU execution unit with a valid/ready handshake on both sides.
// Shifts run iteratively, one bit per cycle; every other op resolves in one cycle.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_control,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] work;
  logic [31:0] work_nxt;
  logic [31:0] op_res;
  logic [4:0]  cnt;
  logic        shr;
  logic        accept;
  logic        is_shift;
  logic [4:0]  shamt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign zero      = (alu_result == 32'h0);

  assign accept   = in_valid && in_ready;
  assign is_shift = (alu_control[1:0] == 2'b01);
  assign shamt    = src_b[4:0];
  assign work_nxt = shr ? (work >> 1) : (work << 1);

  // Shift opcodes land here only with shamt == 0, where the result is src_a unchanged.
  always_comb begin
    op_res = 32'h0;
    case (alu_control)
      3'b000:         op_res = src_a + src_b;
      3'b010:         op_res = src_a - src_b;
      3'b100:         op_res = src_a ^ src_b;
      3'b110:         op_res = src_a | src_b;
      3'b111:         op_res = src_a & src_b;
      3'b001, 3'b101: op_res = src_a;
      default:        op_res = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (is_shift && shamt != 5'd0) ? SHIFT : DONE;
      SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result <= 32'h0;
      work       <= 32'h0;
      cnt        <= 5'd0;
      shr        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (is_shift && shamt != 5'd0) begin
            work <= src_a;
            cnt  <= shamt;
            shr  <= alu_control[2];
          end else begin
            alu_result <= op_res;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) alu_result <= work_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
